// File: rtl/cache_refill_unit_if.sv
// Bus bundle for cache_refill_unit: pipeline miss request, memory burst
// channel and data/tag array write port. master = refill unit side.
interface cache_refill_unit_if #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
);
   localparam int IDX_W = $clog2(LINE_WORDS);

   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              hit;
   logic              cache_miss_detected;
   logic              refill_complete;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_data;
   logic              line_we;
   logic [IDX_W-1:0]  line_word_idx;
   logic [DATA_W-1:0] line_wdata;
   logic              tag_we;
   logic [ADDR_W-1:0] tag_addr;

   modport master (
      input  req_valid,
      input  req_addr,
      input  hit,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_data,
      output cache_miss_detected,
      output refill_complete,
      output mem_req_valid,
      output mem_req_addr,
      output line_we,
      output line_word_idx,
      output line_wdata,
      output tag_we,
      output tag_addr
   );

   modport slave (
      output req_valid,
      output req_addr,
      output hit,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_data,
      input  cache_miss_detected,
      input  refill_complete,
      input  mem_req_valid,
      input  mem_req_addr,
      input  line_we,
      input  line_word_idx,
      input  line_wdata,
      input  tag_we,
      input  tag_addr
   );
endinterface

// File: rtl/cache_refill_unit.sv
// L1 miss engine: burst line refill, tag written last.
// Optional macro CRITICAL_WORD_FIRST_EN: wrap-order burst from missed word.
module cache_refill_unit #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input logic                clk,
   input logic                rst,
   cache_refill_unit_if.master io_bus
);
   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam int WOFF  = $clog2(DATA_W / 8);
   localparam int OFF   = IDX_W + WOFF;
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_FILL = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [IDX_W-1:0]  r_beat;

   logic              w_miss;
   logic              w_req_fire;
   logic              w_beat;
   logic              w_last;
   logic [ADDR_W-1:0] w_line_addr;
   logic [IDX_W-1:0]  w_woff;
   logic              w_unused;

   assign w_miss     = (r_state == S_IDLE)
                     && io_bus.req_valid && !io_bus.hit;
   assign w_req_fire = (r_state == S_REQ) && io_bus.mem_req_ready;
   assign w_beat     = (r_state == S_FILL) && io_bus.mem_rsp_valid;
   assign w_last     = w_beat && (r_beat == LAST_BEAT);

   assign w_line_addr = {r_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
   assign w_woff      = r_addr[OFF-1:WOFF];
   assign w_unused    = &{1'b0, r_addr[WOFF-1:0], w_woff};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_beat  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_miss) begin
                  r_addr  <= io_bus.req_addr;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (w_req_fire) begin
                  r_beat  <= '0;
                  r_state <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_beat) begin
                  r_beat <= r_beat + IDX_W'(1);
                  if (w_last) r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.cache_miss_detected = (r_state == S_REQ)
                                    || (r_state == S_FILL);
   assign io_bus.mem_req_valid   = (r_state == S_REQ);
   // Tag goes in only after every word landed, so no partial line can hit
   assign io_bus.tag_we          = (r_state == S_DONE);
   assign io_bus.refill_complete = (r_state == S_DONE);
   assign io_bus.tag_addr        = w_line_addr;
   assign io_bus.line_we         = w_beat;
   assign io_bus.line_wdata      = io_bus.mem_rsp_data;

`ifdef CRITICAL_WORD_FIRST_EN
   assign io_bus.mem_req_addr  = {r_addr[ADDR_W-1:WOFF], {WOFF{1'b0}}};
   assign io_bus.line_word_idx = w_woff + r_beat;
`else
   assign io_bus.mem_req_addr  = w_line_addr;
   assign io_bus.line_word_idx = r_beat;
`endif

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed scoreboard bench for cache_refill_unit.
// Expected array writes are queued as beats are driven.
module tb_cache_refill_unit;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;
`ifdef CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]    idx;
      logic [DW-1:0] data;
   } wr_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_mis;
   int   cyc;
   int   n_wr;
   int   n_tag;
   int   n_missc;
   int   t_tag;
   wr_t  q[$];

   cache_refill_unit_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) bus ();

   cache_refill_unit #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.cache_miss_detected) n_missc++;
      if (bus.tag_we) begin
         n_tag++;
         t_tag = cyc;
      end
      if (bus.line_we) begin
         wr_t e;
         n_wr++;
         chk("wr_pending", 64'(q.size() > 0), 64'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_idx", 64'(bus.line_word_idx), 64'(e.idx));
            chk("wr_data", 64'(bus.line_wdata), 64'(e.data));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctrl(input string tag, input logic [4:0] exp);
      chk(tag, 64'({bus.cache_miss_detected, bus.refill_complete,
                    bus.mem_req_valid, bus.line_we, bus.tag_we}),
          64'(exp));
   endtask

   task automatic refill(input logic [AW-1:0] a, input int rdly,
                         input int bubble, input bit stray);
      logic [AW-1:0] exp_req;
      logic [AW-1:0] exp_tag;
      logic [1:0]    woff;
      logic [DW-1:0] d;
      int            e0;
      int            nb;
      exp_tag = {a[AW-1:4], 4'h0};
      exp_req = CWF ? {a[AW-1:2], 2'b00} : exp_tag;
      woff    = CWF ? a[3:2] : 2'd0;
      nb      = (bubble >= 0) ? 1 : 0;
      n_wr = 0; n_tag = 0; n_missc = 0;
      bus.req_addr  = a;
      bus.req_valid = 1'b1;
      bus.hit       = 1'b0;
      step();
      e0 = cyc;
      bus.req_addr = 32'h0000_FFF0;
      for (int i = 0; i <= rdly; i++) begin
         bus.mem_req_ready = (i == rdly);
         bus.mem_rsp_valid = stray && (i == 0);
         bus.mem_rsp_data  = 32'hBAD0_0000;
         @(negedge clk);
         chk_ctrl("req_ctrl", 5'b10100);
         chk("req_addr", 64'(bus.mem_req_addr), 64'(exp_req));
         step();
      end
      bus.req_valid     = 1'b0;
      bus.mem_req_ready = 1'b0;
      for (int b = 0; b < LW; b++) begin
         if (bubble == b) begin
            bus.mem_rsp_valid = 1'b0;
            @(negedge clk);
            chk_ctrl("bubble", 5'b10000);
            step();
         end
         d = $urandom;
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = d;
         q.push_back('{idx: 2'(woff + 2'(b)), data: d});
         step();
      end
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      @(negedge clk);
      chk_ctrl("done_ctrl", 5'b01001);
      chk("tag_addr", 64'(bus.tag_addr), 64'(exp_tag));
      step();
      @(negedge clk);
      chk_ctrl("idle_after", 5'b00000);
      chk("n_writes", 64'(n_wr), 64'(LW));
      chk("q_empty", 64'(q.size()), 64'd0);
      chk("n_tag", 64'(n_tag), 64'd1);
      chk("latency", 64'(t_tag + 1 - e0), 64'(LW + 2 + rdly + nb));
      chk("miss_cycles", 64'(n_missc), 64'(LW + 1 + rdly + nb));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] d;
      n_cmp = 0; n_mis = 0; cyc = 0;
      n_wr = 0; n_tag = 0; n_missc = 0; t_tag = 0;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.hit = 1'b0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data = '0;
      rst = 1'b1;
      #12;
      chk_ctrl("rst_ctrl", 5'b00000);
      chk("rst_req_addr", 64'(bus.mem_req_addr), 64'd0);
      chk("rst_tag_addr", 64'(bus.tag_addr), 64'd0);
      chk("rst_idx", 64'(bus.line_word_idx), 64'd0);
      step();
      rst = 1'b0;
      step();

      bus.req_valid = 1'b1; bus.hit = 1'b1; bus.req_addr = 32'h100;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_ctrl("hit_ctrl", 5'b00000);
         chk("hit_req_addr", 64'(bus.mem_req_addr), 64'd0);
         step();
      end
      bus.req_valid = 1'b0; bus.hit = 1'b0;
      step();

      refill(32'h104, 0, -1, 1'b0);
      refill(32'h208, 3, -1, 1'b0);
      refill(32'h314, 0, 2, 1'b1);

      n_wr = 0; n_tag = 0;
      bus.req_addr = 32'h420; bus.req_valid = 1'b1; bus.hit = 1'b0;
      step();
      bus.req_valid = 1'b0;
      bus.mem_req_ready = 1'b1;
      step();
      bus.mem_req_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         d = $urandom;
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = d;
         q.push_back('{idx: 2'(b), data: d});
         step();
      end
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      #1 rst = 1'b1;
      #1;
      chk_ctrl("midrst_ctrl", 5'b00000);
      chk("midrst_req_addr", 64'(bus.mem_req_addr), 64'd0);
      chk("midrst_tag_addr", 64'(bus.tag_addr), 64'd0);
      step();
      rst = 1'b0;
      step();
      step();
      chk("midrst_writes", 64'(n_wr), 64'd2);
      chk("midrst_no_tag", 64'(n_tag), 64'd0);
      chk("midrst_q", 64'(q.size()), 64'd0);

      refill(32'h500, 0, -1, 1'b0);
      refill(32'h10C, 1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end
endmodule
